// File: rtl/gameover_overlay.sv
// Final pixel stage: pass-through / staged fade / blinking game-over banner, switched only at frame starts.
// Latency is a fixed 2 clk for rgb, syncs and DE; runs every clock and has no backpressure.
module gameover_overlay #(
  parameter int unsigned FADE_FRAMES  = 8,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned BOX_X0       = 160,
  parameter int unsigned BOX_X1       = 480,
  parameter int unsigned BOX_Y0       = 200,
  parameter int unsigned BOX_Y1       = 280,
  parameter logic [11:0] BOX_RGB      = 12'hF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        DE,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [11:0] cam_rgb,
  input  logic        game_over,
  input  logic        restart,
  output logic [11:0] rgb_out,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        DE_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_FADE = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [9:0] X0 = 10'(BOX_X0);
  localparam logic [9:0] X1 = 10'(BOX_X1);
  localparam logic [9:0] Y0 = 10'(BOX_Y0);
  localparam logic [9:0] Y1 = 10'(BOX_Y1);
  localparam logic [7:0] FADE_LAST  = 8'(FADE_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // stage 1
  logic        de1_q, de1_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic [11:0] cam1_q, cam1_d;
  logic        in_box1_q, in_box1_d;
  logic        fs1_q, fs1_d;
  logic        prev_nz_q, prev_nz_d;

  // stage 2
  logic [11:0] rgb2_q, rgb2_d;
  logic        hs2_q, hs2_d;
  logic        vs2_q, vs2_d;
  logic        de2_q, de2_d;

  // game state
  state_t      state_q, state_d;
  logic [2:0]  lvl_q, lvl_d;
  logic [7:0]  frm_q, frm_d;
  logic        blink_q, blink_d;
  logic        pend_over_q, pend_over_d;
  logic        pend_rst_q, pend_rst_d;

  logic        pix_zero;
  logic [11:0] pix;

  always_comb begin
    pix_zero  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    de1_d     = DE;
    hs1_d     = h_sync;
    vs1_d     = v_sync;
    cam1_d    = cam_rgb;
    in_box1_d = (h_cnt >= X0) && (h_cnt < X1) && (v_cnt >= Y0) && (v_cnt < Y1);
    fs1_d     = pix_zero && prev_nz_q;
    prev_nz_d = !pix_zero;
  end

  // Flags consumed at a frame start are dropped; a request landing on that same clock survives.
  always_comb begin
    pend_over_d = fs1_q ? 1'b0 : pend_over_q;
    pend_rst_d  = fs1_q ? 1'b0 : pend_rst_q;
    if (game_over) begin
      pend_over_d = 1'b1;
      pend_rst_d  = 1'b0;
    end else if (restart) begin
      pend_rst_d  = 1'b1;
      pend_over_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    if (fs1_q) begin
      case (state_q)
        ST_PLAY: begin
          if (pend_over_q) begin
            state_d = ST_FADE;
            lvl_d   = 3'd0;
            frm_d   = 8'd0;
          end
        end
        ST_FADE: begin
          if (pend_rst_q) begin
            state_d = ST_PLAY;
            lvl_d   = 3'd0;
            frm_d   = 8'd0;
          end else if (frm_q == FADE_LAST) begin
            frm_d = 8'd0;
            if (lvl_q == 3'd4) begin
              state_d = ST_OVER;
              blink_d = 1'b1;
            end else begin
              lvl_d = lvl_q + 3'd1;
            end
          end else begin
            frm_d = frm_q + 8'd1;
          end
        end
        ST_OVER: begin
          if (pend_rst_q) begin
            state_d = ST_PLAY;
            lvl_d   = 3'd0;
            frm_d   = 8'd0;
            blink_d = 1'b0;
          end else if (frm_q == BLINK_LAST) begin
            frm_d   = 8'd0;
            blink_d = !blink_q;
          end else begin
            frm_d = frm_q + 8'd1;
          end
        end
        default: state_d = ST_PLAY;
      endcase
    end
  end

  // Colour uses the next-state values so the frame-start pixel already shows the new mode.
  always_comb begin
    pix = 12'h000;
    case (state_d)
      ST_PLAY: pix = cam1_q;
      ST_FADE: pix = {cam1_q[11:8] >> lvl_d, cam1_q[7:4] >> lvl_d, cam1_q[3:0] >> lvl_d};
      ST_OVER: pix = (in_box1_q && blink_d) ? BOX_RGB : 12'h000;
      default: pix = 12'h000;
    endcase
    rgb2_d = de1_q ? pix : 12'h000;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    de2_d  = de1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de1_q       <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      cam1_q      <= 12'h000;
      in_box1_q   <= 1'b0;
      fs1_q       <= 1'b0;
      prev_nz_q   <= 1'b0;
      rgb2_q      <= 12'h000;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      de2_q       <= 1'b0;
      state_q     <= ST_PLAY;
      lvl_q       <= 3'd0;
      frm_q       <= 8'd0;
      blink_q     <= 1'b0;
      pend_over_q <= 1'b0;
      pend_rst_q  <= 1'b0;
    end else begin
      de1_q       <= de1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      cam1_q      <= cam1_d;
      in_box1_q   <= in_box1_d;
      fs1_q       <= fs1_d;
      prev_nz_q   <= prev_nz_d;
      rgb2_q      <= rgb2_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      de2_q       <= de2_d;
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      frm_q       <= frm_d;
      blink_q     <= blink_d;
      pend_over_q <= pend_over_d;
      pend_rst_q  <= pend_rst_d;
    end
  end

  assign rgb_out  = rgb2_q;
  assign h_sync_o = hs2_q;
  assign v_sync_o = vs2_q;
  assign DE_o     = de2_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_gameover_overlay.sv
// Bench for gameover_overlay on a compressed raster: each frame is a short list of probe pixels.
// Expected pixels are queued when driven and popped two clocks later when the DUT emits them.
module tb_gameover_overlay;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        DE = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [11:0] cam_rgb = '0;
  logic        game_over = 1'b0;
  logic        restart = 1'b0;
  logic [11:0] rgb_out;
  logic        h_sync_o;
  logic        v_sync_o;
  logic        DE_o;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  // {h, v, rgb, hs, vs, de}
  logic [34:0] sb[$];

  localparam int NPX = 11;
  int   px_h   [0:NPX-1] = '{0, 320, 100, 480, 479, 160, 159, 320, 320, 700, 700};
  int   px_v   [0:NPX-1] = '{0, 240, 100, 240, 279, 200, 240, 280, 199, 240, 500};
  bit   px_de  [0:NPX-1] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  bit   px_hs  [0:NPX-1] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
  bit   px_vs  [0:NPX-1] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit   px_box [0:NPX-1] = '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};

  gameover_overlay #(
    .FADE_FRAMES (2),
    .BLINK_FRAMES(2),
    .BOX_X0      (160),
    .BOX_X1      (480),
    .BOX_Y0      (200),
    .BOX_Y1      (280),
    .BOX_RGB     (12'hF00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .DE       (DE),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .cam_rgb  (cam_rgb),
    .game_over(game_over),
    .restart  (restart),
    .rgb_out  (rgb_out),
    .h_sync_o (h_sync_o),
    .v_sync_o (v_sync_o),
    .DE_o     (DE_o),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic drive_px(input logic [9:0] h, input logic [9:0] v, input logic de,
                          input logic hs, input logic vs, input logic [11:0] cam,
                          input logic go, input logic rs, input logic [11:0] exp_rgb);
    logic [34:0] e;
    h_cnt     = h;
    v_cnt     = v;
    DE        = de;
    h_sync    = hs;
    v_sync    = vs;
    cam_rgb   = cam;
    game_over = go;
    restart   = rs;
    sb.push_back({h, v, exp_rgb, hs, vs, de});
    @(posedge clk);
    #1;
    game_over = 1'b0;
    restart   = 1'b0;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      n_cmp++;
      if ({rgb_out, h_sync_o, v_sync_o, DE_o} !== e[14:0]) begin
        n_err++;
        $display("FAIL pixel(%0d,%0d): got rgb=%h hs=%b vs=%b de=%b, want rgb=%h hs=%b vs=%b de=%b",
                 e[34:25], e[24:15], rgb_out, h_sync_o, v_sync_o, DE_o,
                 e[14:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic run_frame(input logic [1:0] exp_st, input logic [11:0] cam,
                           input logic [11:0] exp_act, input logic exp_box,
                           input int go_at, input int rs_at);
    logic [11:0] e;
    for (int i = 0; i < NPX; i++) begin
      if (!px_de[i])
        e = 12'h000;
      else if (exp_st == 2'd2)
        e = (px_box[i] && exp_box) ? 12'hF00 : 12'h000;
      else
        e = exp_act;
      for (int c = 0; c < 4; c++)
        drive_px(10'(px_h[i]), 10'(px_v[i]), px_de[i], px_hs[i], px_vs[i], cam,
                 (i == go_at) && (c == 0), (i == rs_at) && (c == 0), e);
    end
    n_cmp++;
    if (state_o !== exp_st) begin
      n_err++;
      $display("FAIL frame_state: got %0d, want %0d", state_o, exp_st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (rgb_out  !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
    n_cmp++; if (h_sync_o !== 1'b1)    begin n_err++; $display("FAIL reset_hs: got %b want 1", h_sync_o); end
    n_cmp++; if (v_sync_o !== 1'b1)    begin n_err++; $display("FAIL reset_vs: got %b want 1", v_sync_o); end
    n_cmp++; if (DE_o     !== 1'b0)    begin n_err++; $display("FAIL reset_de: got %b want 0", DE_o); end
    n_cmp++; if (state_o  !== 2'd0)    begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    reset = 1'b1;
  endtask

  task automatic test_pass_through();
    run_frame(2'd0, 12'hABC, 12'hABC, 1'b0, -1, -1);
    run_frame(2'd0, 12'h123, 12'h123, 1'b0, -1, -1);
    run_frame(2'd0, 12'h5A0, 12'h5A0, 1'b0, -1, -1);
  endtask

  task automatic test_fade();
    logic [11:0] steps [0:4];
    steps[0] = 12'hFFF; steps[1] = 12'h777; steps[2] = 12'h333;
    steps[3] = 12'h111; steps[4] = 12'h000;
    run_frame(2'd0, 12'hFFF, 12'hFFF, 1'b0, 2, -1);
    for (int k = 1; k <= 10; k++)
      run_frame(2'd1, 12'hFFF, steps[(k - 1) / 2], 1'b0, -1, -1);
    run_frame(2'd2, 12'hFFF, 12'h000, 1'b1, -1, -1);
  endtask

  task automatic test_blink();
    run_frame(2'd2, 12'hFFF, 12'h000, 1'b1, -1, -1);
    run_frame(2'd2, 12'hFFF, 12'h000, 1'b0, 3, -1);   // game_over while OVER is ignored
    run_frame(2'd2, 12'hFFF, 12'h000, 1'b0, -1, -1);
    run_frame(2'd2, 12'hFFF, 12'h000, 1'b1, -1, -1);
    run_frame(2'd2, 12'hFFF, 12'h000, 1'b1, -1, -1);
  endtask

  task automatic test_reset_mid_over();
    repeat (4) drive_px(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0, 12'h000);
    repeat (2) drive_px(10'd320, 10'd300, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0, 12'h000);
    n_cmp++;
    if (state_o !== 2'd2) begin n_err++; $display("FAIL pre_reset_state: got %0d want 2", state_o); end
    reset = 1'b0;
    #1;
    n_cmp++; if (state_o !== 2'd0)    begin n_err++; $display("FAIL midreset_state: got %0d want 0", state_o); end
    n_cmp++; if (rgb_out !== 12'h000) begin n_err++; $display("FAIL midreset_rgb: got %h want 000", rgb_out); end
    n_cmp++; if (DE_o    !== 1'b0)    begin n_err++; $display("FAIL midreset_de: got %b want 0", DE_o); end
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    run_frame(2'd0, 12'h0F0, 12'h0F0, 1'b0, -1, -1);
    run_frame(2'd0, 12'h0F0, 12'h0F0, 1'b0, -1, -1);
  endtask

  task automatic test_restart();
    run_frame(2'd0, 12'h888, 12'h888, 1'b0, 1, -1);
    run_frame(2'd1, 12'h888, 12'h888, 1'b0, -1, -1);
    run_frame(2'd1, 12'h888, 12'h888, 1'b0, -1, -1);
    run_frame(2'd1, 12'h888, 12'h444, 1'b0, -1, 5);
    run_frame(2'd0, 12'h888, 12'h888, 1'b0, -1, -1);
  endtask

  task automatic test_collision();
    run_frame(2'd0, 12'h963, 12'h963, 1'b0, 2, 2);    // same-clock: game_over wins
    run_frame(2'd1, 12'h963, 12'h963, 1'b0, -1, 6);
    run_frame(2'd0, 12'h963, 12'h963, 1'b0, 1, 3);    // later restart cancels game_over
    run_frame(2'd0, 12'h963, 12'h963, 1'b0, -1, 2);   // restart in PLAY has no effect
    run_frame(2'd0, 12'h963, 12'h963, 1'b0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fade();
    test_blink();
    test_reset_mid_over();
    test_restart();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
